// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage.
// Holds the program counter and issues word-aligned requests to instruction memory.
// In-order responses are collected into a small {instr, pc} FIFO that feeds decode.
// A redirect flushes the FIFO. Responses for requests still in flight at the
// redirect are counted so they can be discarded when they arrive.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // One extra bit so a count can hold DEPTH itself.
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);

  typedef logic [CW-1:0] cnt_t;

  logic [31:0] fetch_pc;
  logic [31:0] resp_pc;
  cnt_t        inflight;
  cnt_t        drop;
  cnt_t        fifo_count;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [31:0] fifo_instr [DEPTH];
  logic [31:0] fifo_pc    [DEPTH];

  logic        req_fire;
  logic        resp_accept;
  logic        resp_drop;
  logic        push;
  logic        pop;
  logic [CW:0] credits_used;
  cnt_t        inflight_next;
  logic [31:0] redirect_aligned;

  // The low two bits of redirect_pc are discarded by word alignment.
  logic unused_redirect_bits;
  assign unused_redirect_bits = ^redirect_pc[1:0];

  assign redirect_aligned = {redirect_pc[31:2], 2'b00};

  // The credit check uses only registered counts and redirect_valid.
  // It never looks at imem_req_ready, so the request valid cannot form a loop with memory.
  assign credits_used   = {1'b0, inflight} + {1'b0, fifo_count};
  assign imem_req_valid = !reset && !redirect_valid && (credits_used < DEPTH_W);
  assign imem_req_addr  = fetch_pc;
  assign req_fire       = imem_req_valid && imem_req_ready;

  // A response with nothing in flight is a protocol violation and is ignored.
  assign resp_accept   = imem_resp_valid && (inflight != '0);
  assign resp_drop     = resp_accept && (drop != '0);
  assign push          = resp_accept && !resp_drop;
  assign pop           = instr_valid && instr_ready;
  assign inflight_next = inflight + cnt_t'(req_fire) - cnt_t'(resp_accept);

  // Decode always sees the FIFO head. There is no bypass from the response port.
  assign instr_valid = (fifo_count != '0);
  assign instr       = fifo_instr[rd_ptr];
  assign instr_pc    = fifo_pc[rd_ptr];

  // PCs, outstanding and drop counters, and FIFO pointers. Redirect overrides normal flow.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc   <= RESET_PC;
      resp_pc    <= RESET_PC;
      inflight   <= '0;
      drop       <= '0;
      fifo_count <= '0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
    end else if (redirect_valid) begin
      fetch_pc   <= redirect_aligned;
      resp_pc    <= redirect_aligned;
      inflight   <= inflight_next;
      // Every request still outstanding after this cycle belongs to the old path.
      drop       <= inflight_next;
      fifo_count <= '0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
    end else begin
      inflight <= inflight_next;
      if (req_fire) begin
        fetch_pc <= fetch_pc + 32'd4;
      end
      if (resp_drop) begin
        drop <= drop - 1'b1;
      end
      if (push) begin
        resp_pc <= resp_pc + 32'd4;
        wr_ptr  <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      fifo_count <= fifo_count + cnt_t'(push) - cnt_t'(pop);
    end
  end

  // FIFO storage. Words are written on push; a redirect in the same cycle suppresses the write.
  // NOTE: storage is reset so instr and instr_pc read as zero after reset, not stale words.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        fifo_instr[i] <= '0;
        fifo_pc[i]    <= '0;
      end
    end else if (push && !redirect_valid) begin
      fifo_instr[wr_ptr] <= imem_resp_data;
      fifo_pc[wr_ptr]    <= resp_pc;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: checks fetch_unit against a scoreboard.
// A modelled instruction memory returns responses in order after a programmable latency.
// Every accepted request pushes its expected PC; every decode handshake pops one and compares.
module tb_fetch_unit;

  localparam int DEPTH = 2;

  logic        clk;
  logic        reset;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;

  fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(DEPTH)) dut (
    .clk             (clk),
    .reset           (reset),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .instr_valid     (instr_valid),
    .instr_ready     (instr_ready),
    .instr           (instr),
    .instr_pc        (instr_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;

  mreq_t       mq[$];       // requests accepted by the memory model, awaiting response
  logic [31:0] exp_q[$];    // scoreboard: PCs expected at decode, in order
  logic [31:0] fired_q[$];  // log of accepted request addresses
  logic [31:0] pop_log[$];  // log of PCs consumed by decode
  int          cyc;
  int          lat;
  int          checks;
  int          failures;

  // Values sampled mid-cycle in the most recent tick.
  logic        s_req_valid;
  logic [31:0] s_addr;
  logic        s_ivalid;
  logic [31:0] s_instr;
  logic [31:0] s_ipc;

  // Instruction words differ from their address, so swapped fields are detected.
  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return a ^ 32'hDEAD_0000;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // One clock cycle: drive inputs at negedge, sample and update the models, then wait for posedge.
  task automatic tick(input logic rst, input logic redir, input logic [31:0] rpc,
                      input logic rdy, input logic irdy);
    logic [31:0] e;
    @(negedge clk);
    reset          = rst;
    redirect_valid = redir;
    redirect_pc    = rpc;
    imem_req_ready = rdy;
    instr_ready    = irdy;
    if (!rst && mq.size() > 0 && mq[0].due <= cyc) begin
      imem_resp_valid = 1'b1;
      imem_resp_data  = mem_data(mq[0].addr);
    end else begin
      imem_resp_valid = 1'b0;
      imem_resp_data  = 32'h0;
    end
    #1;
    s_req_valid = imem_req_valid;
    s_addr      = imem_req_addr;
    s_ivalid    = instr_valid;
    s_instr     = instr;
    s_ipc       = instr_pc;
    if (!rst && instr_valid && instr_ready) begin
      if (exp_q.size() == 0) begin
        check("pop_unexpected", {31'b0, instr_valid}, 32'h0);
      end else begin
        e = exp_q.pop_front();
        check("instr_pc", instr_pc, e);
        check("instr", instr, mem_data(e));
        pop_log.push_back(instr_pc);
      end
    end
    if (!rst && imem_req_valid && imem_req_ready) begin
      mq.push_back('{addr: imem_req_addr, due: cyc + lat});
      exp_q.push_back(imem_req_addr);
      fired_q.push_back(imem_req_addr);
      check("outstanding_le_depth", {31'b0, mq.size() <= DEPTH}, 32'h1);
    end
    if (imem_resp_valid) begin
      void'(mq.pop_front());
    end
    if (rst) begin
      mq.delete();
      exp_q.delete();
    end else if (redir) begin
      exp_q.delete();
    end
    @(posedge clk);
    cyc++;
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int  first_valid;
    bit  found;
    checks          = 0;
    failures        = 0;
    cyc             = 0;
    lat             = 1;
    reset           = 1'b1;
    redirect_valid  = 1'b0;
    redirect_pc     = 32'h0;
    imem_req_ready  = 1'b0;
    imem_resp_valid = 1'b0;
    imem_resp_data  = 32'h0;
    instr_ready     = 1'b0;

    // Reset state.
    repeat (3) tick(1, 0, 0, 1, 1);
    check("rst_req_valid", {31'b0, s_req_valid}, 32'h0);
    check("rst_req_addr", s_addr, 32'h0);
    check("rst_instr_valid", {31'b0, s_ivalid}, 32'h0);
    check("rst_instr", s_instr, 32'h0);
    check("rst_instr_pc", s_ipc, 32'h0);

    // Streaming with latency 1: first request right after reset; first instruction two cycles later.
    fired_q.delete();
    first_valid = -1;
    for (int k = 0; k < 30; k++) begin
      tick(0, 0, 0, 1, 1);
      if (k == 0) begin
        check("first_req_valid", {31'b0, s_req_valid}, 32'h1);
        check("first_req_addr", s_addr, 32'h0);
      end
      if (s_ivalid && first_valid < 0) first_valid = k;
    end
    check("first_instr_cycle", first_valid, 2);
    check("fired_count_ge3", {31'b0, fired_q.size() >= 3}, 32'h1);
    if (fired_q.size() >= 3) begin
      check("seq_addr1", fired_q[1], 32'h4);
      check("seq_addr2", fired_q[2], 32'h8);
    end

    // Decode stalled: exactly DEPTH requests, then the request valid stays low.
    repeat (2) tick(1, 0, 0, 1, 1);
    fired_q.delete();
    repeat (10) tick(0, 0, 0, 1, 0);
    check("stall_fired", fired_q.size(), DEPTH);
    check("stall_req_low", {31'b0, s_req_valid}, 32'h0);
    check("stall_head_valid", {31'b0, s_ivalid}, 32'h1);
    check("stall_head_pc", s_ipc, 32'h0);
    repeat (6) tick(0, 0, 0, 1, 1);
    check("resume_fired", {31'b0, fired_q.size() >= 3}, 32'h1);
    if (fired_q.size() >= 3) check("resume_addr", fired_q[2], 32'h8);

    // Redirect while FIFO is full and decode is popping in the same cycle.
    repeat (10) tick(0, 0, 0, 1, 0);
    check("full_before_redirect", {31'b0, s_ivalid}, 32'h1);
    tick(0, 1, 32'h0000_0200, 1, 1);
    tick(0, 0, 0, 1, 1);
    check("redir_full_instr_valid", {31'b0, s_ivalid}, 32'h0);
    check("redir_full_req_valid", {31'b0, s_req_valid}, 32'h1);
    check("redir_full_req_addr", s_addr, 32'h0000_0200);
    repeat (10) tick(0, 0, 0, 1, 1);

    // Memory ready toggling with latency 3: addresses advance only on acceptance.
    lat = 3;
    fired_q.delete();
    for (int k = 0; k < 40; k++) tick(0, 0, 0, (k % 2) == 0, 1);
    for (int i = 1; i < fired_q.size(); i++) begin
      check("toggle_addr_step", fired_q[i], fired_q[i-1] + 32'd4);
    end
    for (int k = 0; k < 20 && (exp_q.size() > 0 || mq.size() > 0); k++) tick(0, 0, 0, 0, 1);
    check("toggle_drained", exp_q.size(), 0);

    // Two requests in flight (0x10, 0x14); redirect coincides with the 0x10 response.
    tick(0, 1, 32'h0000_0010, 1, 1);
    fired_q.delete();
    found = 0;
    for (int k = 0; k < 50 && !found; k++) begin
      if (mq.size() == 2 && mq[0].due <= cyc) begin
        found = 1;
        check("inflight_addr0", mq[0].addr, 32'h10);
        check("inflight_addr1", mq[1].addr, 32'h14);
        tick(0, 1, 32'h0000_0102, 1, 1);
      end else begin
        tick(0, 0, 0, 1, 1);
      end
    end
    check("redir_window_found", {31'b0, found}, 32'h1);
    pop_log.delete();
    tick(0, 0, 0, 1, 1);
    check("redir_instr_valid_low", {31'b0, s_ivalid}, 32'h0);
    check("redir_req_valid", {31'b0, s_req_valid}, 32'h1);
    check("redir_req_addr", s_addr, 32'h0000_0100);
    repeat (20) tick(0, 0, 0, 1, 1);
    check("redir_delivered", {31'b0, pop_log.size() > 0}, 32'h1);
    if (pop_log.size() > 0) check("redir_first_pc", pop_log[0], 32'h0000_0100);

    // Address wrap at the top of the address space.
    lat = 1;
    for (int k = 0; k < 10 && mq.size() > 0; k++) tick(0, 0, 0, 0, 1);
    tick(0, 1, 32'hFFFF_FFFE, 1, 1);
    fired_q.delete();
    pop_log.delete();
    repeat (8) tick(0, 0, 0, 1, 1);
    check("wrap_fired", {31'b0, fired_q.size() >= 2}, 32'h1);
    if (fired_q.size() >= 2) begin
      check("wrap_addr0", fired_q[0], 32'hFFFF_FFFC);
      check("wrap_addr1", fired_q[1], 32'h0000_0000);
    end
    if (pop_log.size() >= 2) check("wrap_pop1", pop_log[1], 32'h0000_0000);

    // Reset mid-stream: outputs return to reset values one cycle later.
    repeat (3) tick(0, 0, 0, 1, 0);
    tick(1, 0, 0, 1, 1);
    check("midrst_req_valid", {31'b0, s_req_valid}, 32'h0);
    tick(0, 0, 0, 1, 1);
    check("midrst_instr_valid", {31'b0, s_ivalid}, 32'h0);
    check("midrst_instr", s_instr, 32'h0);
    check("midrst_instr_pc", s_ipc, 32'h0);
    check("midrst_req_addr", s_addr, 32'h0);
    check("midrst_req_valid_after", {31'b0, s_req_valid}, 32'h1);
    repeat (10) tick(0, 0, 0, 1, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
